// File: rtl/circuit_2_if.sv
// circuit_2_if: signal bundle for the filtered XOR cell.
//   A, B : raw level inputs, asynchronous to the cell clock (driven by master)
//   S    : registered XOR of the debounced A/B levels (driven by slave)
interface circuit_2_if;
  logic A;
  logic B;
  logic S;

  modport master (
    output A,
    output B,
    input  S
  );

  modport slave (
    input  A,
    input  B,
    output S
  );
endinterface

// File: rtl/circuit_2.sv
// circuit_2: two-input filtered exclusive-OR cell.
// Each raw input is passed through a two-flop synchronizer and an independent
// debounce filter; S is the registered XOR of the two filtered levels.
// Ports:
//   clk   : rising-edge system clock
//   rst_n : asynchronous active-low reset (clears all state, S = 0)
//   bus   : circuit_2_if.slave -- A, B raw inputs; S filtered XOR output
// Parameter:
//   DEBOUNCE : consecutive mismatching samples needed before a filtered
//              level follows its synchronized input (1..255)
module circuit_2 #(
  parameter int DEBOUNCE = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  circuit_2_if.slave    bus
);

  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

  logic             a_s1_q, a_s2_q, b_s1_q, b_s2_q;
  logic [CNT_W-1:0] a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
  logic             a_filt_q, a_filt_d, b_filt_q, b_filt_d;
  logic             s_q, s_d;

  // Filter next state for channel A. Any matching sample clears the count,
  // so only an unbroken run of DEBOUNCE mismatches moves the filtered level.
  always_comb begin
    a_cnt_d  = a_cnt_q;
    a_filt_d = a_filt_q;
    if (a_s2_q == a_filt_q) begin
      a_cnt_d = '0;
    end else if (a_cnt_q == CNT_LAST) begin
      a_filt_d = a_s2_q;
      a_cnt_d  = '0;
    end else begin
      a_cnt_d = a_cnt_q + CNT_W'(1);
    end
  end

  // Filter next state for channel B; identical to A and fully independent.
  always_comb begin
    b_cnt_d  = b_cnt_q;
    b_filt_d = b_filt_q;
    if (b_s2_q == b_filt_q) begin
      b_cnt_d = '0;
    end else if (b_cnt_q == CNT_LAST) begin
      b_filt_d = b_s2_q;
      b_cnt_d  = '0;
    end else begin
      b_cnt_d = b_cnt_q + CNT_W'(1);
    end
  end

  // XOR of the current filtered levels; registered so S is glitch-free.
  always_comb begin
    s_d = a_filt_q ^ b_filt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_s1_q   <= 1'b0;
      a_s2_q   <= 1'b0;
      b_s1_q   <= 1'b0;
      b_s2_q   <= 1'b0;
      a_cnt_q  <= '0;
      b_cnt_q  <= '0;
      a_filt_q <= 1'b0;
      b_filt_q <= 1'b0;
      s_q      <= 1'b0;
    end else begin
      // synchronizer stage
      a_s1_q   <= bus.A;
      a_s2_q   <= a_s1_q;
      b_s1_q   <= bus.B;
      b_s2_q   <= b_s1_q;
      // debounce stage
      a_cnt_q  <= a_cnt_d;
      a_filt_q <= a_filt_d;
      b_cnt_q  <= b_cnt_d;
      b_filt_q <= b_filt_d;
      // output stage
      s_q      <= s_d;
    end
  end

  assign bus.S = s_q;

endmodule

// File: tb/tb_circuit_2.sv
module tb_circuit_2;

  logic clk    = 1'b0;
  logic clk_en = 1'b0;
  logic rst_n;
  int   total  = 0;
  int   bad    = 0;

  circuit_2_if bus ();

  circuit_2 #(.DEBOUNCE(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 if (clk_en) clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and sample 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] pat [4];
  logic       pexp [4];
  logic       prev;

  initial begin
    pat[0] = 2'b00; pexp[0] = 1'b0;
    pat[1] = 2'b01; pexp[1] = 1'b1;
    pat[2] = 2'b10; pexp[2] = 1'b1;
    pat[3] = 2'b11; pexp[3] = 1'b0;

    // Reset with no clock running
    rst_n = 1'b1;
    bus.A = 1'b1;
    bus.B = 1'b0;
    #2 rst_n = 1'b0;
    #2 check("reset_noclk_a", bus.S, 1'b0);
    #30 check("reset_noclk_b", bus.S, 1'b0);

    // Release; A=1,B=0 held -> S rises on edge 7
    clk_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      check($sformatf("reset_rel_e%0d", k), bus.S, (k >= 7) ? 1'b1 : 1'b0);
    end

    // Truth table, each pattern held 10 cycles
    prev = 1'b1;
    for (int p = 0; p < 4; p++) begin
      {bus.A, bus.B} = pat[p];
      for (int k = 1; k <= 10; k++) begin
        step();
        check($sformatf("tt_p%0d_c%0d", p, k), bus.S, (k >= 7) ? pexp[p] : prev);
      end
      prev = pexp[p];
    end

    // Both fall together from 11 -> S stays 0
    bus.A = 1'b0;
    bus.B = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      check($sformatf("fall11_c%0d", k), bus.S, 1'b0);
    end

    // Glitch of 3 cycles rejected
    bus.A = 1'b1;
    repeat (3) step();
    bus.A = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      check($sformatf("glitch3_c%0d", k), bus.S, 1'b0);
    end

    // Pulse of 4 cycles: S high on edges 7..10
    bus.A = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step();
      if (k == 4) bus.A = 1'b0;
      check($sformatf("pulse4_e%0d", k), bus.S, (k >= 7 && k <= 10) ? 1'b1 : 1'b0);
    end

    // Interrupted mismatch: high 3, low 1, high held -> S rises on edge 11
    bus.A = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 3) bus.A = 1'b0;
      if (k == 4) bus.A = 1'b1;
      check($sformatf("interrupt_e%0d", k), bus.S, (k >= 11) ? 1'b1 : 1'b0);
    end
    bus.A = 1'b0;
    repeat (12) step();
    check("interrupt_settle", bus.S, 1'b0);

    // Simultaneous rise and fall of both inputs
    bus.A = 1'b1;
    bus.B = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      check($sformatf("simul_rise_c%0d", k), bus.S, 1'b0);
    end
    bus.A = 1'b0;
    bus.B = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      check($sformatf("simul_fall_c%0d", k), bus.S, 1'b0);
    end

    // Reset mid-count with S high beforehand
    bus.B = 1'b1;
    repeat (10) step();
    check("midrst_pre", bus.S, 1'b1);
    bus.A = 1'b1;
    repeat (2) step();
    #2 rst_n = 1'b0;
    bus.B = 1'b0;
    #1 check("midrst_async", bus.S, 1'b0);
    repeat (2) step();
    check("midrst_held", bus.S, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      check($sformatf("midrst_rel_e%0d", k), bus.S, (k >= 7) ? 1'b1 : 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
